shift_arbiter: RTL and testbench

//   Shares one W-bit left-shift datapath (result = data << shamt, truncated
//   to W bits) among N requesters.
//   - Round-robin arbitration; one transaction in flight at a time.
//   - LAT-cycle multicycle shift stage.
//   - Response is held under a valid/ready handshake.

---
 rtl/shift_arbiter_if.sv | 30 +++
 rtl/shift_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_shift_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// Requester/response bundle for the shared shifter arbiter.
// The master side is the requester/consumer; the slave side is the arbiter.
interface shift_arbiter_if #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int SHW = 2
);
  localparam int IDW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     req;
  logic [N*W-1:0]   req_data;
  logic [N*SHW-1:0] req_shamt;
  logic [N-1:0]     req_ack;
  logic             resp_valid;
  logic             resp_ready;
  logic [W-1:0]     resp_data;
  logic [IDW-1:0]   resp_id;
  logic             resp_ovf;
  logic             busy;

  modport master (
    output req, req_data, req_shamt, resp_ready,
    input  req_ack, resp_valid, resp_data, resp_id, resp_ovf, busy
  );

  modport slave (
    input  req, req_data, req_shamt, resp_ready,
    output req_ack, resp_valid, resp_data, resp_id, resp_ovf, busy
  );
endinterface

// File: rtl/shift_arbiter.sv
// One W-bit left shifter shared round-robin among N requesters, one transaction
// in flight, LAT-cycle shift stage and a held valid/ready response.
module shift_arbiter #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int SHW = 2,
  parameter int LAT = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  shift_arbiter_if.slave bus
);
  localparam int IDW  = (N > 1) ? $clog2(N) : 1;
  localparam int CNTW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_id;
  logic [W-1:0]    r_data;
  logic [SHW-1:0]  r_shamt;
  logic [CNTW-1:0] r_cnt;
  logic            r_resp_valid;
  logic [W-1:0]    r_resp_data;
  logic [IDW-1:0]  r_resp_id;
  logic            r_resp_ovf;
  logic            w_gnt_vld;
  logic [IDW-1:0]  w_gnt_id;
  logic [IDW:0]    w_sum;
  logic [IDW-1:0]  w_idx;
  logic [W-1:0]    w_sel_data;
  logic [SHW-1:0]  w_sel_shamt;
  logic [N-1:0]    w_ack;
  logic            w_accept;
  logic            w_shift_done;
  logic            w_resp_hs;
  logic [W:0]      w_result;
  logic [IDW-1:0]  w_rr_nxt;

  // Returns {ovf, result}; shifts of W or more push every data bit out.
  function automatic logic [W:0] shl_ovf(input logic [W-1:0] d, input logic [SHW-1:0] s);
    logic [2*W-1:0] full;
    full = {{W{1'b0}}, d} << s;
    if (32'(s) >= 32'(W)) begin
      shl_ovf = {(d != {W{1'b0}}), {W{1'b0}}};
    end else begin
      shl_ovf = {(full[2*W-1:W] != {W{1'b0}}), full[W-1:0]};
    end
  endfunction

  // Round-robin pick: scan offsets high to low so the nearest set bit wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_id  = {IDW{1'b0}};
    w_sum     = {(IDW+1){1'b0}};
    w_idx     = {IDW{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      w_idx = (w_sum >= (IDW+1)'(N)) ? IDW'(w_sum - (IDW+1)'(N)) : IDW'(w_sum);
      if (bus.req[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_id  = w_idx;
      end else begin
        w_gnt_vld = w_gnt_vld;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_data  = {W{1'b0}};
    w_sel_shamt = {SHW{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (w_gnt_id == IDW'(k)) begin
        w_sel_data  = bus.req_data[k*W +: W];
        w_sel_shamt = bus.req_shamt[k*SHW +: SHW];
      end else begin
        w_sel_data  = w_sel_data;
      end
    end
  end

  // Acknowledge is combinational, IDLE-only, and forced low while in reset.
  always_comb begin
    w_ack = {N{1'b0}};
    if ((r_state == ST_IDLE) && w_gnt_vld && rst_n) begin
      w_ack[w_gnt_id] = 1'b1;
    end else begin
      w_ack = {N{1'b0}};
    end
  end

  // Next-state decode and transaction events.
  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_shift_done = 1'b0;
    w_resp_hs    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_gnt_vld) begin
          w_state_nxt = ST_SHIFT;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_cnt == CNTW'(1)) begin
          w_state_nxt  = ST_RESP;
          w_shift_done = 1'b1;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_RESP: begin
        if (r_resp_valid && bus.resp_ready) begin
          w_state_nxt = ST_IDLE;
          w_resp_hs   = 1'b1;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_result = shl_ovf(r_data, r_shamt);
  assign w_rr_nxt = (r_id == IDW'(N - 1)) ? {IDW{1'b0}} : r_id + IDW'(1);

  // Operand capture, latency count, response registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data       <= {W{1'b0}};
      r_shamt      <= {SHW{1'b0}};
      r_id         <= {IDW{1'b0}};
      r_cnt        <= {CNTW{1'b0}};
      r_resp_valid <= 1'b0;
      r_resp_data  <= {W{1'b0}};
      r_resp_id    <= {IDW{1'b0}};
      r_resp_ovf   <= 1'b0;
      r_rr_ptr     <= {IDW{1'b0}};
    end else begin
      if (w_accept) begin
        r_data  <= w_sel_data;
        r_shamt <= w_sel_shamt;
        r_id    <= w_gnt_id;
        r_cnt   <= CNTW'(LAT);
      end else if (r_state == ST_SHIFT) begin
        r_cnt <= r_cnt - CNTW'(1);
      end
      if (w_shift_done) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_result[W-1:0];
        r_resp_ovf   <= w_result[W];
        r_resp_id    <= r_id;
      end else if (w_resp_hs) begin
        r_resp_valid <= 1'b0;
      end
      if (w_resp_hs) begin
        r_rr_ptr <= w_rr_nxt;
      end
    end
  end

  assign bus.req_ack    = w_ack;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_id    = r_resp_id;
  assign bus.resp_ovf   = r_resp_ovf;
  assign bus.busy       = (r_state != ST_IDLE);
endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: LAT=1 instance for most scenarios,
// LAT=3 instance for the multicycle latency case.
module tb_shift_arbiter;
  typedef struct packed {
    logic [1:0] id;
    logic [3:0] data;
    logic       ovf;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   exp_ptr;
  exp_t sb_q[$];
  logic [3:0] td [4];
  logic [1:0] ts [4];

  shift_arbiter_if #(.N(4), .W(4), .SHW(2)) bus ();
  shift_arbiter_if #(.N(4), .W(4), .SHW(2)) bus3 ();

  shift_arbiter #(.N(4), .W(4), .SHW(2), .LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  shift_arbiter #(.N(4), .W(4), .SHW(2), .LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int id, input logic [3:0] d, input logic [1:0] s);
    exp_t e;
    int   full;
    full   = int'(d) * (1 << s);
    e.id   = 2'(id);
    e.data = 4'(full % 16);
    e.ovf  = (full >= 16);
    return e;
  endfunction

  function automatic int model_grant(input logic [3:0] r, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (((r >> ((ptr + k) % 4)) & 4'b0001) != 4'b0000) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  task automatic drive_req(input int i, input logic [3:0] d, input logic [1:0] s);
    bus.req[i]               = 1'b1;
    bus.req_data[i*4 +: 4]   = d;
    bus.req_shamt[i*2 +: 2]  = s;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ptr = 0;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    bus.req         = 4'b1111;
    bus.req_data    = 16'hFFFF;
    bus.req_shamt   = 8'hFF;
    bus.resp_ready  = 1'b1;
    bus3.req        = 4'b0000;
    bus3.req_data   = 16'h0000;
    bus3.req_shamt  = 8'h00;
    bus3.resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_ovf, bus.req_ack, bus.busy} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, expected all zero",
               {bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_ovf, bus.req_ack, bus.busy});
    end
    n_cmp++;
    if ({bus3.resp_valid, bus3.req_ack, bus3.busy} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_lat3: got %b, expected 000000", {bus3.resp_valid, bus3.req_ack, bus3.busy});
    end
    bus.req = 4'b0000;
    rst_n   = 1'b1;
    exp_ptr = 0;
  endtask

  task automatic test_basic();
    exp_t e, got;
    int   lat;
    @(negedge clk);
    drive_req(0, 4'b0011, 2'd2);
    #1;
    n_cmp++;
    if (bus.req_ack !== 4'b0001) begin
      n_err++;
      $display("FAIL basic_ack: got %b, expected 0001", bus.req_ack);
    end
    sb_q.push_back(model(0, 4'b0011, 2'd2));
    exp_ptr = 1;
    @(negedge clk);
    bus.req = 4'b0000;
    #1;
    n_cmp++;
    if ({bus.req_ack, bus.busy, bus.resp_valid} !== 6'b0000_1_0) begin
      n_err++;
      $display("FAIL basic_shift: got ack/busy/valid %b, expected 000010", {bus.req_ack, bus.busy, bus.resp_valid});
    end
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    n_cmp++;
    if (lat != 1) begin
      n_err++;
      $display("FAIL basic_latency: got %0d edges, expected 1", lat);
    end
    e   = sb_q.pop_front();
    got = {bus.resp_id, bus.resp_data, bus.resp_ovf};
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL basic_resp: got id/data/ovf %b, expected %b", got, e);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus.resp_valid, bus.busy, bus.resp_data} !== {1'b0, 1'b0, e.data}) begin
      n_err++;
      $display("FAIL basic_after_hs: got %b, expected %b", {bus.resp_valid, bus.busy, bus.resp_data}, {2'b00, e.data});
    end
  endtask

  task automatic test_ovf_cases();
    logic [3:0] dv [3];
    logic [1:0] sv [3];
    exp_t e, got;
    int   lat;
    dv = '{4'b1011, 4'b1011, 4'b1111};
    sv = '{2'd1, 2'd0, 2'd3};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_req(2, dv[c], sv[c]);
      #1;
      n_cmp++;
      if (bus.req_ack !== 4'b0100) begin
        n_err++;
        $display("FAIL ovf_ack[%0d]: got %b, expected 0100", c, bus.req_ack);
      end
      sb_q.push_back(model(2, dv[c], sv[c]));
      exp_ptr = 3;
      @(negedge clk);
      bus.req = 4'b0000;
      #1;
      lat = 0;
      while (bus.resp_valid !== 1'b1 && lat < 20) begin
        @(negedge clk); #1; lat++;
      end
      e   = sb_q.pop_front();
      got = {bus.resp_id, bus.resp_data, bus.resp_ovf};
      n_cmp++;
      if (lat != 1 || got !== e) begin
        n_err++;
        $display("FAIL ovf_resp[%0d]: got id/data/ovf %b after %0d edges, expected %b after 1", c, got, lat, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    int   order [6];
    int   n_ack, n_resp, last_ack, want;
    exp_t e, got;
    order = '{0, 1, 2, 3, 0, 1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      td[i] = 4'($urandom_range(0, 15));
      ts[i] = 2'($urandom_range(0, 3));
      drive_req(i, td[i], ts[i]);
    end
    n_ack = 0; n_resp = 0; last_ack = 0;
    for (int cyc = 0; cyc < 60 && n_resp < 6; cyc++) begin
      #1;
      if (bus.req_ack !== 4'b0000 && n_ack < 6) begin
        want = order[n_ack];
        n_cmp++;
        if (bus.req_ack !== (4'b0001 << want) || (n_ack > 0 && cyc - last_ack != 3)) begin
          n_err++;
          $display("FAIL rr_grant[%0d]: got ack %b after %0d cycles, expected %b after 3",
                   n_ack, bus.req_ack, cyc - last_ack, 4'b0001 << want);
        end
        sb_q.push_back(model(want, td[want], ts[want]));
        exp_ptr  = (want + 1) % 4;
        last_ack = cyc;
        n_ack++;
      end
      if (bus.resp_valid === 1'b1 && sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = {bus.resp_id, bus.resp_data, bus.resp_ovf};
        n_cmp++;
        if (got !== e) begin
          n_err++;
          $display("FAIL rr_resp[%0d]: got id/data/ovf %b, expected %b", n_resp, got, e);
        end
        n_resp++;
      end
      @(negedge clk);
      if (n_ack == 6) bus.req = 4'b0000;
    end
    n_cmp++;
    if (n_resp != 6 || n_ack != 6) begin
      n_err++;
      $display("FAIL rr_count: got %0d acks / %0d responses, expected 6 / 6", n_ack, n_resp);
    end
  endtask

  task automatic test_stall();
    exp_t e, got;
    int   g, lat;
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_req(i, td[i], ts[i]);
    #1;
    g = model_grant(4'b1111, exp_ptr);
    n_cmp++;
    if (bus.req_ack !== (4'b0001 << g)) begin
      n_err++;
      $display("FAIL stall_ack: got %b, expected %b", bus.req_ack, 4'b0001 << g);
    end
    sb_q.push_back(model(g, td[g], ts[g]));
    exp_ptr = (g + 1) % 4;
    @(negedge clk); #1;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    e = sb_q.pop_front();
    for (int c = 1; c <= 6; c++) begin
      got = {bus.resp_id, bus.resp_data, bus.resp_ovf};
      n_cmp++;
      if (got !== e || bus.resp_valid !== 1'b1 || bus.req_ack !== 4'b0000) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got id/data/ovf %b valid %b ack %b, expected %b valid 1 ack 0000",
                 c, got, bus.resp_valid, bus.req_ack, e);
      end
      if (c == 6) bus.resp_ready = 1'b1;
      @(negedge clk); #1;
    end
    g = model_grant(4'b1111, exp_ptr);
    n_cmp++;
    if (bus.req_ack !== (4'b0001 << g) || bus.resp_valid !== 1'b0 || bus.resp_data !== e.data) begin
      n_err++;
      $display("FAIL stall_next: got ack %b valid %b data %b, expected ack %b valid 0 data %b",
               bus.req_ack, bus.resp_valid, bus.resp_data, 4'b0001 << g, e.data);
    end
    bus.req = 4'b0000;
    @(negedge clk); #1;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL stall_drop: got busy %b, expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, got;
    int   lat;
    @(negedge clk);
    drive_req(1, 4'b0101, 2'd1);
    #1;
    n_cmp++;
    if (bus.req_ack !== 4'b0010) begin
      n_err++;
      $display("FAIL rstmid_ack: got %b, expected 0010", bus.req_ack);
    end
    @(negedge clk);
    bus.req = 4'b0000;
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_ovf, bus.req_ack, bus.busy} !== 13'd0) begin
      n_err++;
      $display("FAIL rstmid_outputs: got %b, expected all zero",
               {bus.resp_valid, bus.resp_data, bus.resp_id, bus.resp_ovf, bus.req_ack, bus.busy});
    end
    @(negedge clk);
    rst_n   = 1'b1;
    exp_ptr = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++;
      if ({bus.resp_valid, bus.busy, bus.req_ack} !== 6'd0) begin
        n_err++;
        $display("FAIL rstmid_quiet[%0d]: got valid/busy/ack %b, expected 000000", c, {bus.resp_valid, bus.busy, bus.req_ack});
      end
      @(negedge clk);
    end
    bus.req = 4'b1010;
    #1;
    n_cmp++;
    if (bus.req_ack !== (4'b0001 << model_grant(4'b1010, exp_ptr))) begin
      n_err++;
      $display("FAIL rstmid_ptr: got %b, expected 0010", bus.req_ack);
    end
    bus.req = 4'b0000;
    @(negedge clk);
    drive_req(3, 4'b0111, 2'd1);
    #1;
    n_cmp++;
    if (bus.req_ack !== 4'b1000) begin
      n_err++;
      $display("FAIL rstmid_ack3: got %b, expected 1000", bus.req_ack);
    end
    sb_q.push_back(model(3, 4'b0111, 2'd1));
    @(negedge clk);
    bus.req = 4'b0000;
    #1;
    lat = 0;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    e   = sb_q.pop_front();
    got = {bus.resp_id, bus.resp_data, bus.resp_ovf};
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL rstmid_resp: got id/data/ovf %b, expected %b", got, e);
    end
    @(negedge clk);
  endtask

  task automatic test_lat3();
    exp_t e, got;
    int   lat;
    @(negedge clk);
    bus3.req           = 4'b0010;
    bus3.req_data[7:4] = 4'b0001;
    bus3.req_shamt[3:2] = 2'd3;
    #1;
    n_cmp++;
    if (bus3.req_ack !== 4'b0010) begin
      n_err++;
      $display("FAIL lat3_ack: got %b, expected 0010", bus3.req_ack);
    end
    sb_q.push_back(model(1, 4'b0001, 2'd3));
    @(negedge clk);
    bus3.req = 4'b0000;
    #1;
    lat = 0;
    while (bus3.resp_valid !== 1'b1 && lat < 20) begin
      @(negedge clk); #1; lat++;
    end
    n_cmp++;
    if (lat != 3) begin
      n_err++;
      $display("FAIL lat3_latency: got %0d edges, expected 3", lat);
    end
    e   = sb_q.pop_front();
    got = {bus3.resp_id, bus3.resp_data, bus3.resp_ovf};
    n_cmp++;
    if (got !== e) begin
      n_err++;
      $display("FAIL lat3_resp: got id/data/ovf %b, expected %b", got, e);
    end
    @(negedge clk); #1;
    n_cmp++;
    if ({bus3.resp_valid, bus3.busy} !== 2'b00 || sb_q.size() != 0) begin
      n_err++;
      $display("FAIL lat3_done: got valid/busy %b with %0d pending, expected 00 with 0",
               {bus3.resp_valid, bus3.busy}, sb_q.size());
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    exp_ptr = 0;
    test_reset();
    test_basic();
    test_ovf_cases();
    test_round_robin();
    test_stall();
    test_reset_mid();
    test_lat3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
